// File: rtl/imem_loader_arb.sv
// imem_loader_arb
//
// Owns the single port of the instruction memory and shares it between a
// streaming program loader and the fetch stage. The pipeline is held in reset
// while a program is loaded. It is then released to run from address 0. In
// RUN, every fetch is checked for alignment and range. A bad PC returns a NOP
// and sets a sticky fault flag.
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   load_start, load_len        start a load of load_len words (any state)
//   ld_valid, ld_data, ld_ready loader word stream (valid/ready)
//   fetch_req, fetch_pc         fetch stage PC (byte address)
//   fetch_instr                 instruction returned to fetch (0 = NOP)
//   core_rst                    active-high pipeline reset
//   load_done                   one-cycle pulse while in FLUSH
//   fault                       sticky bad-fetch flag
//   fetch_count                 good fetches since the last load_start
//   mem_we, mem_addr, mem_wdata memory write/address port
//   mem_rdata                   combinational memory read data at mem_addr

module imem_loader_arb #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  output logic [31:0]       fetch_instr,
  output logic              core_rst,
  output logic              load_done,
  output logic              fault,
  output logic [31:0]       fetch_count,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // DEPTH expressed in the (ADDR_W+1)-bit length domain.
  localparam logic [ADDR_W:0] DepthW = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] OneW   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StRun} state_e;

  state_e          state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] len_q, len_d;
  logic            fault_q, fault_d;
  logic [31:0]     fetch_count_q, fetch_count_d;

  logic [ADDR_W:0] len_clamped;
  logic            pc_good;
  logic            accept;

  assign len_clamped = (load_len > DepthW) ? DepthW : load_len;

  // Word-aligned and inside the memory window.
  assign pc_good = (fetch_pc[1:0] == 2'b00) && (fetch_pc[31:ADDR_W+2] == '0);

  // Moore outputs: decoded from the state register only.
  assign ld_ready  = (state_q == StLoad);
  assign load_done = (state_q == StFlush);
  assign core_rst  = (state_q != StRun);

  assign accept    = ld_valid & ld_ready;
  assign mem_we    = accept;
  assign mem_wdata = ld_data;

  assign fault       = fault_q;
  assign fetch_count = fetch_count_q;

  always_comb begin
    mem_addr    = '0;
    fetch_instr = '0;
    unique case (state_q)
      StLoad: mem_addr = wr_ptr_q[ADDR_W-1:0];
      StRun: begin
        mem_addr = fetch_pc[ADDR_W+1:2];
        if (pc_good) fetch_instr = mem_rdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    len_d         = len_q;
    fault_d       = fault_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      StIdle: ;
      StLoad: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + OneW;
          if (wr_ptr_q == len_q - OneW) state_d = StFlush;
        end
      end
      StFlush: state_d = StRun;
      StRun: begin
        if (fetch_req) begin
          if (pc_good) fetch_count_d = fetch_count_q + 32'd1;
          else         fault_d       = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new load overrides whatever else happens on this edge.
    if (load_start) begin
      wr_ptr_d      = '0;
      len_d         = len_clamped;
      fault_d       = 1'b0;
      fetch_count_d = '0;
      state_d       = (len_clamped == '0) ? StFlush : StLoad;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      len_q         <= '0;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      len_q         <= len_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_imem_loader_arb.sv
// Directed testbench for imem_loader_arb with a behavioural memory model.

module tb_imem_loader_arb;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              ld_ready;
  logic              fetch_req;
  logic [31:0]       fetch_pc;
  logic [31:0]       fetch_instr;
  logic              core_rst;
  logic              load_done;
  logic              fault;
  logic [31:0]       fetch_count;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0] mem [DEPTH];
  int          wr_count;
  int          base;
  int          n_pass;
  int          n_total;
  int          k;

  imem_loader_arb #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_len   (load_len),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .fetch_req  (fetch_req),
    .fetch_pc   (fetch_pc),
    .fetch_instr(fetch_instr),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .fault      (fault),
    .fetch_count(fetch_count),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-ported memory: synchronous write, combinational read.
  assign mem_rdata = mem[mem_addr];
  initial wr_count = 0;
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b0; load_start = 1'b0; load_len = '0; ld_valid = 1'b0; ld_data = '0;
    fetch_req = 1'b0; fetch_pc = '0;

    // Reset values
    #2;
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fetch_count", fetch_count, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_fetch_instr", fetch_instr, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    #10 rst = 1'b1;
    tick();

    // Load of 4 words, streamed back to back
    load_start = 1'b1; load_len = 11'd4;
    tick();
    load_start = 1'b0;
    base = wr_count;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = 32'(i + 1) * 32'h11;
      #1;
      if (i == 0) begin
        check("load_ld_ready", 32'(ld_ready), 32'd1);
        check("load_core_rst", 32'(core_rst), 32'd1);
        check("load_mem_we", 32'(mem_we), 32'd1);
        check("load_done_early", 32'(load_done), 32'd0);
      end
      check("load_mem_addr", 32'(mem_addr), 32'(i));
      tick();
    end
    ld_valid = 1'b0;
    #1;
    check("flush_load_done", 32'(load_done), 32'd1);
    check("flush_core_rst", 32'(core_rst), 32'd1);
    check("flush_ld_ready", 32'(ld_ready), 32'd0);
    check("load4_writes", 32'(wr_count - base), 32'd4);
    check("mem0", mem[0], 32'h11);
    check("mem3", mem[3], 32'h44);
    tick();
    check("run_core_rst", 32'(core_rst), 32'd0);
    check("run_load_done", 32'(load_done), 32'd0);

    // Good fetches
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_pc = 32'(i * 4);
      #1;
      check("fetch_instr", fetch_instr, 32'(i + 1) * 32'h11);
      tick();
    end
    fetch_req = 1'b0;
    #1;
    check("fetch_count3", fetch_count, 32'd3);
    check("fault_clear", 32'(fault), 32'd0);

    // Misaligned and out-of-range fetches
    fetch_req = 1'b1; fetch_pc = 32'h6;
    #1;
    check("misaligned_nop", fetch_instr, 32'd0);
    tick();
    fetch_pc = 32'(DEPTH * 4);
    #1;
    check("range_nop", fetch_instr, 32'd0);
    check("fault_set", 32'(fault), 32'd1);
    tick();
    fetch_req = 1'b0; fetch_pc = 32'h0;
    #1;
    check("fault_sticky", 32'(fault), 32'd1);
    check("count_unchanged", fetch_count, 32'd3);
    tick();
    check("fault_sticky2", 32'(fault), 32'd1);

    // Same load with ld_valid toggled
    load_start = 1'b1; load_len = 11'd4;
    tick();
    load_start = 1'b0;
    base = wr_count;
    #1;
    check("reload_fault_clr", 32'(fault), 32'd0);
    check("reload_count_clr", fetch_count, 32'd0);
    for (int j = 0; j < 7; j++) begin
      ld_valid = (j % 2 == 0);
      ld_data = 32'hA1 + 32'(j / 2);
      #1;
      if (!ld_valid) check("toggle_no_we", 32'(mem_we), 32'd0);
      tick();
    end
    ld_valid = 1'b0;
    #1;
    check("toggle_load_done", 32'(load_done), 32'd1);
    check("toggle_writes", 32'(wr_count - base), 32'd4);
    check("toggle_mem1", mem[1], 32'hA2);
    check("toggle_mem3", mem[3], 32'hA4);
    tick();
    fetch_req = 1'b1; fetch_pc = 32'hC;
    #1;
    check("toggle_fetch", fetch_instr, 32'hA4);
    tick();
    fetch_pc = 32'h1;
    tick();
    fetch_req = 1'b0; fetch_pc = 32'h0;
    #1;
    check("count_after2", fetch_count, 32'd1);
    check("fault_after2", 32'(fault), 32'd1);

    // Zero-length load
    load_start = 1'b1; load_len = 11'd0;
    base = wr_count;
    tick();
    load_start = 1'b0; ld_valid = 1'b1; ld_data = 32'hDEAD;
    #1;
    check("len0_load_done", 32'(load_done), 32'd1);
    check("len0_no_we", 32'(mem_we), 32'd0);
    check("len0_fault", 32'(fault), 32'd0);
    check("len0_count", fetch_count, 32'd0);
    tick();
    ld_valid = 1'b0;
    #1;
    check("len0_run", 32'(core_rst), 32'd0);
    check("len0_writes", 32'(wr_count - base), 32'd0);

    // Reset mid-load
    load_start = 1'b1; load_len = 11'd8;
    tick();
    load_start = 1'b0;
    base = wr_count;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = 32'hB0 + 32'(i);
      tick();
    end
    ld_data = 32'hB3;
    #1;
    rst = 1'b0;
    #1;
    check("midrst_core_rst", 32'(core_rst), 32'd1);
    check("midrst_ld_ready", 32'(ld_ready), 32'd0);
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    tick();
    check("midrst_writes", 32'(wr_count - base), 32'd3);
    check("midrst_mem3", mem[3], 32'hA4);
    rst = 1'b1; ld_valid = 1'b0;
    tick();
    check("idle_ld_ready", 32'(ld_ready), 32'd0);

    // Oversized load is clamped to DEPTH words
    load_start = 1'b1; load_len = 11'(DEPTH + 5);
    tick();
    load_start = 1'b0;
    base = wr_count;
    ld_valid = 1'b1;
    k = 0;
    while (k < int'(DEPTH) + 50) begin
      ld_data = 32'hC000_0000 + 32'(k);
      #1;
      if (load_done) break;
      tick();
      k++;
    end
    check("big_words", 32'(k), 32'(DEPTH));
    check("big_load_done", 32'(load_done), 32'd1);
    check("big_writes", 32'(wr_count - base), 32'(DEPTH));
    check("big_flush_no_we", 32'(mem_we), 32'd0);
    check("big_mem0", mem[0], 32'hC000_0000);
    ld_valid = 1'b0;
    tick();
    fetch_req = 1'b1; fetch_pc = 32'((DEPTH - 1) * 4);
    #1;
    check("big_last_fetch", fetch_instr, 32'hC000_0000 + 32'(DEPTH - 1));
    tick();
    fetch_req = 1'b0;
    #1;
    check("big_count", fetch_count, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
